// File: rtl/conversor_bcd_resultado_if.sv
// Interface between the Booth multiplier side (master) and the BCD converter (slave).
interface conversor_bcd_resultado_if;
    logic        inicio;
    logic [15:0] resultado;
    logic        signo;
    logic [19:0] bcd;
    logic        valido;
    logic        ocupado;

    modport master (
        output inicio,
        output resultado,
        input  signo,
        input  bcd,
        input  valido,
        input  ocupado
    );

    modport slave (
        input  inicio,
        input  resultado,
        output signo,
        output bcd,
        output valido,
        output ocupado
    );
endinterface

// File: rtl/conversor_bcd_resultado.sv
// Signed 16-bit product to sign + five BCD digits, one double-dabble step per cycle.
// Optional macro CONV_BCD_BLANK_EN: replace leading zero digits (never units) with 0xF.
module conversor_bcd_resultado (
    input logic                          clk,
    input logic                          rst,
    conversor_bcd_resultado_if.slave     bus
);

    typedef enum logic [1:0] {StIdle, StConvierte, StListo} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] scratch_q, scratch_d;
    logic [15:0] mag_q, mag_d;
    logic        sign_q, sign_d;
    logic        signo_q, signo_d;
    logic [19:0] bcd_q, bcd_d;
    logic        valido_q, ocupado_q;

    logic [19:0] adjusted;
    logic [19:0] shifted;
    logic [19:0] bcd_out;

    // Add-3 correction on every digit, then shift one magnitude bit in.
    always_comb begin
        adjusted = '0;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
        shifted = {adjusted[18:0], mag_q[15]};
    end

    always_comb begin
        bcd_out = shifted;
`ifdef CONV_BCD_BLANK_EN
        begin
            logic leading;
            leading = 1'b1;
            for (int i = 4; i >= 1; i--) begin
                if (leading && (shifted[4*i +: 4] == 4'd0)) begin
                    bcd_out[4*i +: 4] = 4'hF;
                end else begin
                    leading = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        signo_d   = signo_q;
        bcd_d     = bcd_q;
        unique case (state_q)
            StIdle: begin
                if (bus.inicio) begin
                    sign_d    = bus.resultado[15];
                    // 0x8000 negates to itself, which is the correct unsigned 32768.
                    mag_d     = bus.resultado[15] ? (~bus.resultado + 16'd1) : bus.resultado;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = StConvierte;
                end
            end
            StConvierte: begin
                scratch_d = shifted;
                mag_d     = {mag_q[14:0], 1'b0};
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    bcd_d   = bcd_out;
                    signo_d = sign_q;
                    state_d = StListo;
                end
            end
            StListo: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            scratch_q <= '0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            signo_q   <= 1'b0;
            bcd_q     <= '0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            signo_q   <= signo_d;
            bcd_q     <= bcd_d;
            valido_q  <= (state_d == StListo);
            ocupado_q <= (state_d != StIdle);
        end
    end

    assign bus.signo   = signo_q;
    assign bus.bcd     = bcd_q;
    assign bus.valido  = valido_q;
    assign bus.ocupado = ocupado_q;

endmodule

// File: tb/tb_conversor_bcd_resultado.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each valido strobe.
module tb_conversor_bcd_resultado;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   passed;

    typedef struct {
        logic        s;
        logic [19:0] b;
        int          c;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    conversor_bcd_resultado_if bus ();

    conversor_bcd_resultado dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one inicio pulse; optionally register the expected response.
    task automatic start(input logic [15:0] val, input bit push, input logic s,
                         input logic [19:0] b, input string name);
        exp_t e;
        @(negedge clk);
        bus.inicio    = 1'b1;
        bus.resultado = val;
        if (push) begin
            e.s = s; e.b = b; e.c = cyc + 17; e.name = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.inicio = 1'b0;
    endtask

    // Monitor
    int   busy_len;
    logic prev_valido;
    initial begin
        busy_len    = 0;
        prev_valido = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.valido) begin
                check("valido_single_cycle", {31'd0, prev_valido}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valido", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_signo"}, {31'd0, bus.signo}, {31'd0, e.s});
                    check({e.name, "_bcd"}, {12'd0, bus.bcd}, {12'd0, e.b});
                    check({e.name, "_latency"}, cyc, e.c);
                end
            end
            prev_valido = bus.valido;
            if (!rst) begin
                busy_len = 0;
            end else if (bus.ocupado) begin
                busy_len++;
            end else if (busy_len != 0) begin
                check("ocupado_length", busy_len, 17);
                busy_len = 0;
            end
        end
    end

    initial begin
        checks        = 0;
        passed        = 0;
        cyc           = 0;
        rst           = 1'b0;
        bus.inicio    = 1'b0;
        bus.resultado = '0;
        #1;
        check("reset_signo", {31'd0, bus.signo}, 32'd0);
        check("reset_bcd", {12'd0, bus.bcd}, 32'd0);
        check("reset_valido", {31'd0, bus.valido}, 32'd0);
        check("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

`ifdef CONV_BCD_BLANK_EN
        start(16'h0000, 1, 1'b0, 20'hFFFF0, "zero");
`else
        start(16'h0000, 1, 1'b0, 20'h00000, "zero");
`endif
        repeat (20) @(negedge clk);
        start(16'hC000, 1, 1'b1, 20'h16384, "neg16384");
        repeat (20) @(negedge clk);
        start(16'h8000, 1, 1'b1, 20'h32768, "min_neg");
        repeat (20) @(negedge clk);
        start(16'h7FFF, 1, 1'b0, 20'h32767, "max_pos");
        repeat (20) @(negedge clk);

        // Busy input ignored
`ifdef CONV_BCD_BLANK_EN
        start(16'h002A, 1, 1'b0, 20'hFFF42, "busy_42");
`else
        start(16'h002A, 1, 1'b0, 20'h00042, "busy_42");
`endif
        repeat (3) @(negedge clk);
        start(16'h0064, 0, 1'b0, 20'h0, "ignored");
        repeat (20) @(negedge clk);
`ifdef CONV_BCD_BLANK_EN
        start(16'h0064, 1, 1'b0, 20'hFF100, "after_idle_100");
`else
        start(16'h0064, 1, 1'b0, 20'h00100, "after_idle_100");
`endif
        repeat (20) @(negedge clk);

        // Reset mid-conversion
        start(16'h1234, 0, 1'b0, 20'h0, "aborted");
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_signo", {31'd0, bus.signo}, 32'd0);
        check("abort_bcd", {12'd0, bus.bcd}, 32'd0);
        check("abort_valido", {31'd0, bus.valido}, 32'd0);
        check("abort_ocupado", {31'd0, bus.ocupado}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
`ifdef CONV_BCD_BLANK_EN
        start(16'hFF85, 1, 1'b1, 20'hFF123, "neg123");
`else
        start(16'hFF85, 1, 1'b1, 20'h00123, "neg123");
`endif
        repeat (22) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/conversor_bcd_resultado.md
# conversor_bcd_resultado

Sequential signed-binary-to-BCD converter that sits directly downstream of the Booth multiplier. It captures the 16-bit signed product when the multiplier's `done` pulses. It then converts the product's magnitude to five BCD digits with a one-iteration-per-cycle double-dabble loop, and presents sign plus digits to the display stage with a one-cycle valid strobe. Results are held stable between conversions so the display never sees intermediate values.

## Interface
Parameters: none (widths fixed by the multiplier: 16-bit product, 5 output digits).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- inicio  input  1  start strobe; connect to multiplier `done`; sampled only in IDLE
- resultado  input  16  signed two's-complement product; sampled on the edge that accepts `inicio`
- signo  output  1  1 = negative result
- bcd  output  20  five BCD digits, [19:16] = ten-thousands … [3:0] = units
- valido  output  1  one-cycle strobe: `signo`/`bcd` just updated
- ocupado  output  1  conversion in progress; `inicio` ignored while high

## Operation
- FSM states: IDLE, CONVIERTE, LISTO.
- IDLE, `inicio`=1 → capture:
  - sign s = resultado[15];
  - magnitude m = s ? −resultado : resultado, as a 16-bit unsigned value. 0x8000 gives m = 32768 with no overflow.
  - Clear the 20-bit scratch BCD register and the 5-bit counter.
  - Go to CONVIERTE.
- CONVIERTE, each cycle:
  - for every scratch digit ≥ 5, add 3 (digit-wise, all five in parallel);
  - shift {scratch_bcd, m} left by one;
  - counter +1.
  - After the 16th iteration (counter reaches 16), go to LISTO and load `bcd` ← scratch and `signo` ← s on that same edge.
- LISTO: `valido`=1 for exactly this cycle; unconditional return to IDLE on next edge.
- `inicio` in CONVIERTE or LISTO: ignored, no queuing.
- Zero result: `signo`=0, `bcd`=0x00000.
- Arithmetic range: |resultado| ≤ 32768 < 99999, so the ten-thousands digit is at most 3. No overflow handling required.
- `bcd`/`signo` change only on the LISTO-entry edge (or reset); held otherwise.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, counter 0, scratch 0, `signo`=0, `bcd`=0x00000, `valido`=0, `ocupado`=0.
- `inicio` sampled high at edge N:
  - `ocupado`=1 from after edge N until edge N+17;
  - 16 iterations performed at edges N+1..N+16;
  - `bcd`/`signo` updated at edge N+16;
  - `valido` high during cycle N+16..N+17;
  - IDLE again after edge N+17.
- Minimum spacing between accepted `inicio` pulses: 18 cycles. The multiplier's own latency already exceeds this.
- Reset asserted mid-conversion: immediate abort to reset values. The partial result is never presented and no `valido` is issued.
- `inicio` held high continuously: a new conversion starts on the first IDLE cycle. `resultado` is re-sampled at that edge.
- `valido` and `ocupado` are registered outputs (no combinational path from inputs).

## Configuration
- Macro `CONV_BCD_BLANK_EN`:
  - Defined: leading-zero blanking. When loading `bcd` at LISTO entry, every digit more significant than the highest nonzero digit is replaced by 0xF (display "blank" code). The units digit is never blanked, so zero shows as 0xFFFF0. Reset value stays 0x00000.
  - Not defined: all five digits are always output as BCD (0–9); 0xF never appears.

## Test plan
- Reset, then `resultado`=0x0000 with one-cycle `inicio` → `valido` 16 cycles after acceptance, `signo`=0, `bcd`=0x00000 (blank build: 0xFFFF0).
- `resultado`=0xC000 (−16384) → `signo`=1, `bcd`=0x16384. `ocupado` high exactly 17 cycles, `valido` exactly one cycle.
- Boundaries:
  - `resultado`=0x8000 → `signo`=1, `bcd`=0x32768;
  - `resultado`=0x7FFF → `signo`=0, `bcd`=0x32767.
- Busy input ignored:
  - start 0x002A (42), pulse `inicio` with 0x0064 at cycle 5 → only one `valido`, with `bcd`=0x00042 (blank build: 0xFFF42);
  - `inicio` 0x0064 after return to IDLE → `bcd`=0x00100 (blank build: 0xFF100).
- Reset mid-conversion:
  - assert `rst`=0 at cycle 8 → outputs 0 immediately, no `valido`;
  - release, then start 0xFF85 (−123) → `signo`=1, `bcd`=0x00123 (blank build: 0xFF123).
